wb_trace_fifo: RTL and testbench
================================

WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the register and memory data width.
REQ-002 SHALL have parameter DEPTH, default 8, giving the FIFO entry count; legal values are powers of two, at least 2.
REQ-003 SHALL have parameter FILTER_X0, default 1; when 1, register writes to x0 are not traced.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  capture enable; when 0, no records are pushed.
REQ-007 SHALL have port reg_write_sig  input  1  core register-file write strobe.
REQ-008 SHALL have port reg_num  input  5  destination register index.
REQ-009 SHALL have port reg_data  input  DATA_W  value written to the register file.
REQ-010 SHALL have port wr  input  1  data-memory write strobe.
REQ-011 SHALL have port rd  input  1  data-memory read strobe.
REQ-012 SHALL have port addr  input  9  data-memory address.
REQ-013 SHALL have ports wr_data and rd_data  input  DATA_W  each; they carry the memory store data and load data respectively.
REQ-014 SHALL have port out_valid  output  1  head record available.
REQ-015 SHALL have port out_ready  input  1  consumer accepts the head record.
REQ-016 SHALL have port out_flags  output  3  {reg_ev, wr, rd} of the head record.
REQ-017 SHALL have ports out_reg_num (5), out_reg_data (DATA_W), out_addr (9), out_mem_data (DATA_W) and out_stamp (16), all outputs, carrying the head record fields.
REQ-018 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-019 SHALL have port drop_count  output  16  count of dropped records.
REQ-020 SHALL have port overflow  output  1  sticky flag, set when any record has been dropped.

Function
REQ-021 SHALL define reg_ev as reg_write_sig AND (FILTER_X0==0 OR reg_num!=0), and an event as en AND (reg_ev OR wr OR rd).
REQ-022 SHALL form at most one record per cycle; simultaneous register and memory activity SHALL merge into that one record.
REQ-023 SHALL build each record as follows:
- flags = {reg_ev, wr, rd}
- reg_num and reg_data = the inputs when reg_ev is set, else 0
- addr = the input when wr or rd is set, else 0
- mem_data = wr_data if wr is set, rd_data if only rd is set, else 0
- stamp = the cycle-counter value in the capture cycle
REQ-024 SHALL run a 16-bit cycle counter that:
- resets to 0
- increments every cycle independently of en
- wraps from 0xFFFF to 0x0000
REQ-025 SHALL push the record on an event when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-026 SHALL define a pop as out_valid AND out_ready.
REQ-027 SHALL have a push-to-visible latency of 1: a record captured in cycle N appears at the head no earlier than cycle N+1 and is never combinationally forwarded.
REQ-028 SHALL assert out_valid exactly when level>0.
REQ-029 SHALL hold the head fields stable while out_valid=1 and out_ready=0.
REQ-030 SHALL, on a simultaneous push and pop, leave level unchanged and preserve FIFO order.
REQ-031 SHALL implement read and write pointers modulo DEPTH so they wrap without gaps.
REQ-032 SHALL, when an event occurs while full with no pop:
- drop the record
- increment drop_count, saturating at 0xFFFF
- set overflow
REQ-033 SHALL keep overflow set until reset.
REQ-034 SHALL drive out_flags, out_reg_num, out_reg_data, out_addr, out_mem_data and out_stamp to 0 when out_valid=0.

Reset
REQ-035 SHALL, on reset=1 at a clock edge, clear pointers, level, cycle counter, drop_count and overflow to 0.
REQ-036 SHALL drive out_valid=0 and all out_* data outputs to 0 in the cycle after reset.
REQ-037 SHALL discard in-flight and stored records on reset mid-operation and not capture events in the reset cycle.

Verification
REQ-038 SHALL be verified by the following directed scenarios:
- Single capture: after reset, cycle 3: reg_write_sig=1, reg_num=5, reg_data=0x12345678, out_ready=1 -> cycle 4: out_valid=1, flags=3'b100, reg_num=5, reg_data=0x12345678, stamp=3, level=1.
- x0 filter: reg_write_sig=1, reg_num=0, wr=rd=0, FILTER_X0=1 -> no push, level stays 0; with FILTER_X0=0 -> one record with flags=3'b100.
- Merge: reg_write_sig=1, reg_num=7, wr=1, addr=0x1F0, wr_data=0xDEADBEEF -> one record with flags=3'b110, addr=0x1F0, mem_data=0xDEADBEEF.
- Overflow: out_ready=0, events in 10 consecutive cycles with DEPTH=8 -> level=8, drop_count=2, overflow=1; then out_ready=1 -> 8 records drained in order with stamps increasing by 1.
- Full push+pop: FIFO full, event with out_ready=1 in the same cycle -> level stays 8, drop_count unchanged, new record at tail.
- Reset mid-stream: level=5, assert reset for 1 cycle -> next cycle level=0, out_valid=0, drop_count=0, overflow=0, stamp restarts at 0.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// Trace capture FIFO: merges register-file and data-memory activity into one
// time-stamped record per cycle and buffers it for a ready/valid consumer.
module wb_trace_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter bit FILTER_X0 = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       reg_write_sig,
  input  logic [4:0]                 reg_num,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [8:0]                 addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_flags,
  output logic [4:0]                 out_reg_num,
  output logic [DATA_W-1:0]          out_reg_data,
  output logic [8:0]                 out_addr,
  output logic [DATA_W-1:0]          out_mem_data,
  output logic [15:0]                out_stamp,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drop_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0]        flags;
    logic [4:0]        reg_num;
    logic [DATA_W-1:0] reg_data;
    logic [8:0]        addr;
    logic [DATA_W-1:0] mem_data;
    logic [15:0]       stamp;
  } rec_t;

  logic [15:0]   r_cycle;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [15:0]   r_drop;
  logic          r_ovf;
  rec_t          r_mem [DEPTH];

  logic w_reg_ev;
  logic w_event;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  rec_t w_rec;
  rec_t w_out;

  assign w_reg_ev = reg_write_sig & (!FILTER_X0 | (reg_num != 5'd0));
  assign w_event  = en & (w_reg_ev | wr | rd);
  assign w_full   = (r_level == LP_FULL);
  assign w_pop    = out_valid & out_ready;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign w_push   = !reset & w_event & (!w_full | w_pop);
  assign w_drop   = w_event & w_full & !w_pop;

  // NOTE: every field gets a default before the conditional overrides, so no latch is inferred.
  always_comb begin
    w_rec       = '0;
    w_rec.flags = {w_reg_ev, wr, rd};
    w_rec.stamp = r_cycle;
    if (w_reg_ev) begin
      w_rec.reg_num  = reg_num;
      w_rec.reg_data = reg_data;
    end
    if (wr || rd) w_rec.addr = addr;
    if (wr)       w_rec.mem_data = wr_data;
    else if (rd)  w_rec.mem_data = rd_data;
  end

  // NOTE: the record storage has no reset; validity is tracked solely by r_level.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_rec;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 16'd1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
    end
  end

  assign out_valid = (r_level != '0);
  assign w_out     = out_valid ? r_mem[r_rptr] : '0;

  assign out_flags    = w_out.flags;
  assign out_reg_num  = w_out.reg_num;
  assign out_reg_data = w_out.reg_data;
  assign out_addr     = w_out.addr;
  assign out_mem_data = w_out.mem_data;
  assign out_stamp    = w_out.stamp;
  assign level        = r_level;
  assign drop_count   = r_drop;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: capture, x0 filtering, merge, overflow,
// full push+pop and mid-stream reset, with hand-computed expectations.
module tb_wb_trace_fifo;

  logic        clk;
  logic        reset;
  logic        en;
  logic        reg_write_sig;
  logic [4:0]  reg_num;
  logic [31:0] reg_data;
  logic        wr;
  logic        rd;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        out_ready;

  logic        out_valid;
  logic [2:0]  out_flags;
  logic [4:0]  out_reg_num;
  logic [31:0] out_reg_data;
  logic [8:0]  out_addr;
  logic [31:0] out_mem_data;
  logic [15:0] out_stamp;
  logic [3:0]  level;
  logic [15:0] drop_count;
  logic        overflow;

  logic        nf_valid;
  logic [2:0]  nf_flags;
  logic [4:0]  nf_reg_num;
  logic [31:0] nf_reg_data;
  logic [8:0]  nf_addr;
  logic [31:0] nf_mem_data;
  logic [15:0] nf_stamp;
  logic [3:0]  nf_level;
  logic [15:0] nf_drop_count;
  logic        nf_overflow;

  int n_checks;
  int n_fails;

  wb_trace_fifo #(.DATA_W(32), .DEPTH(8), .FILTER_X0(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .reg_write_sig(reg_write_sig),
    .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_flags(out_flags), .out_reg_num(out_reg_num),
    .out_reg_data(out_reg_data), .out_addr(out_addr),
    .out_mem_data(out_mem_data), .out_stamp(out_stamp), .level(level),
    .drop_count(drop_count), .overflow(overflow)
  );

  // Unfiltered instance, always draining, used only for the x0 scenario.
  wb_trace_fifo #(.DATA_W(32), .DEPTH(8), .FILTER_X0(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .en(en), .reg_write_sig(reg_write_sig),
    .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .out_valid(nf_valid),
    .out_ready(1'b1), .out_flags(nf_flags), .out_reg_num(nf_reg_num),
    .out_reg_data(nf_reg_data), .out_addr(nf_addr),
    .out_mem_data(nf_mem_data), .out_stamp(nf_stamp), .level(nf_level),
    .drop_count(nf_drop_count), .overflow(nf_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_write_sig = 1'b0;
    reg_num       = '0;
    reg_data      = '0;
    wr            = 1'b0;
    rd            = 1'b0;
    addr          = '0;
    wr_data       = '0;
    rd_data       = '0;
  endtask

  // Ends just after the reset edge: cycle counter reads 0 in the current cycle.
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    en        = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    do_reset();

    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_flags", out_flags, 0);
    check("rst_stamp", out_stamp, 0);

    // Single capture in cycle 3
    step(); step(); step();
    reg_write_sig = 1'b1; reg_num = 5'd5; reg_data = 32'h1234_5678; out_ready = 1'b1;
    #1;
    check("cap_no_forward", out_valid, 0);
    step();
    idle_inputs();
    check("cap_valid", out_valid, 1);
    check("cap_flags", out_flags, 3'b100);
    check("cap_regnum", out_reg_num, 5);
    check("cap_regdata", out_reg_data, 32'h1234_5678);
    check("cap_addr", out_addr, 0);
    check("cap_memdata", out_mem_data, 0);
    check("cap_stamp", out_stamp, 3);
    check("cap_level", level, 1);
    step();
    check("pop_valid", out_valid, 0);
    check("pop_level", level, 0);
    check("idle_regdata_zero", out_reg_data, 0);
    check("idle_stamp_zero", out_stamp, 0);

    // x0 write in cycle 5
    reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = 32'hAAAA_5555;
    step();
    idle_inputs();
    check("x0_filt_level", level, 0);
    check("x0_filt_valid", out_valid, 0);
    check("x0_nf_valid", nf_valid, 1);
    check("x0_nf_flags", nf_flags, 3'b100);
    check("x0_nf_regdata", nf_reg_data, 32'hAAAA_5555);
    check("x0_nf_stamp", nf_stamp, 5);

    // Merge in cycle 6
    reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'h0BAD_F00D;
    wr = 1'b1; addr = 9'h1F0; wr_data = 32'hDEAD_BEEF; rd_data = 32'h1111_1111;
    step();
    idle_inputs();
    check("mrg_flags", out_flags, 3'b110);
    check("mrg_regnum", out_reg_num, 7);
    check("mrg_regdata", out_reg_data, 32'h0BAD_F00D);
    check("mrg_addr", out_addr, 9'h1F0);
    check("mrg_memdata", out_mem_data, 32'hDEAD_BEEF);
    check("mrg_stamp", out_stamp, 6);
    check("mrg_level", level, 1);
    step();

    // Load-only in cycle 8
    rd = 1'b1; addr = 9'h055; rd_data = 32'hCAFE_F00D; wr_data = 32'h99;
    step();
    idle_inputs();
    check("rd_flags", out_flags, 3'b001);
    check("rd_addr", out_addr, 9'h055);
    check("rd_memdata", out_mem_data, 32'hCAFE_F00D);
    check("rd_regnum", out_reg_num, 0);
    check("rd_stamp", out_stamp, 8);
    step();
    check("rd_drained", level, 0);

    // Overflow: events in cycles 10..19, consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1; addr = 9'(i); wr_data = 32'h100 + 32'(i);
      step();
    end
    idle_inputs();
    check("ovf_level", level, 8);
    check("ovf_drop", drop_count, 2);
    check("ovf_flag", overflow, 1);
    check("ovf_head_stamp", out_stamp, 10);
    step();
    check("ovf_hold_stamp", out_stamp, 10);
    check("ovf_hold_addr", out_addr, 0);

    // Full push+pop in cycle 21
    wr = 1'b1; addr = 9'h1AA; wr_data = 32'hF00D_F00D; out_ready = 1'b1;
    step();
    idle_inputs();
    out_ready = 1'b0;
    check("fpp_level", level, 8);
    check("fpp_drop", drop_count, 2);
    check("fpp_head_stamp", out_stamp, 11);

    // Drain: stamps 11..17 then the tail record from cycle 21
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drn_valid", out_valid, 1);
      if (k < 7) begin
        check("drn_stamp", out_stamp, 16'(11 + k));
        check("drn_addr", out_addr, 9'(k + 1));
        check("drn_memdata", out_mem_data, 32'h100 + 32'(k + 1));
      end else begin
        check("drn_tail_stamp", out_stamp, 21);
        check("drn_tail_addr", out_addr, 9'h1AA);
        check("drn_tail_memdata", out_mem_data, 32'hF00D_F00D);
      end
      step();
    end
    check("drn_empty", out_valid, 0);
    check("drn_level", level, 0);
    check("drn_ovf_sticky", overflow, 1);
    check("drn_drop_kept", drop_count, 2);

    // Reset mid-stream with 5 stored records and an event in the reset cycle
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; addr = 9'(i + 32); wr_data = 32'(i);
      step();
    end
    idle_inputs();
    check("mid_level", level, 5);
    rd = 1'b1; addr = 9'h077; rd_data = 32'h5A5A_5A5A;
    do_reset();
    idle_inputs();
    check("mrst_level", level, 0);
    check("mrst_valid", out_valid, 0);
    check("mrst_drop", drop_count, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_addr", out_addr, 0);
    wr = 1'b1; addr = 9'h003; wr_data = 32'h3;
    step();
    idle_inputs();
    check("mrst_stamp0", out_stamp, 0);
    check("mrst_one_rec", level, 1);
    check("mrst_rec_addr", out_addr, 9'h003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
